// File: rtl/mem_pkg.sv
// mem_pkg: shared constants, state type and size decode
// for the memory arbiter and its grant picker.
package mem_pkg;

  localparam logic [31:0] BASE_ADDR = 32'h8002_0000;

  localparam logic [1:0] SZ_1  = 2'b00;
  localparam logic [1:0] SZ_4  = 2'b01;
  localparam logic [1:0] SZ_8  = 2'b10;
  localparam logic [1:0] SZ_16 = 2'b11;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic [4:0] size_to_beats(
    input logic [1:0] size
  );
    logic [4:0] beats;
    unique case (size)
      SZ_1:  beats = 5'd1;
      SZ_4:  beats = 5'd4;
      SZ_8:  beats = 5'd8;
      SZ_16: beats = 5'd16;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select for the arbiter.
// MEM_ARB_RR_EN selects round-robin; otherwise data always wins.
module mem_arb_pick (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic if_req,
  input  logic dm_req,
  output logic if_gnt,
  output logic dm_gnt
);

`ifdef MEM_ARB_RR_EN
  import mem_pkg::*;

  logic last_q;
  logic dm_first;

  // data leads whenever fetch won most recently
  assign dm_first = (last_q == OWNER_IF);

  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (en) begin
      if (dm_req && (dm_first || !if_req)) begin
        dm_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= OWNER_IF;
    end else if (dm_gnt) begin
      last_q <= OWNER_DM;
    end else if (if_gnt) begin
      last_q <= OWNER_IF;
    end
  end
`else
  logic unused_clk;

  assign unused_clk = clock ^ reset;
  assign dm_gnt = en && dm_req;
  assign if_gnt = en && if_req && !dm_req;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: splits fetch/data bursts into single-word accesses.
// Build with MEM_ARB_RR_EN for round-robin arbitration.
module mem_arbiter #(
  parameter logic [31:0] BASE_ADDR = mem_pkg::BASE_ADDR,
  parameter int unsigned MEM_DEPTH = 1048576
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic [1:0]  if_size,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        dm_req,
  input  logic        dm_rw,
  input  logic [31:0] dm_addr,
  input  logic [1:0]  dm_size,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_wack,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic [1:0]  mem_access_size,
  output logic        mem_rw,
  output logic        mem_enable,
  output logic        mem_do_wm_bypass,
  input  logic [31:0] mem_data_out
);

  import mem_pkg::*;

  state_t      state, state_n;
  logic        owner_q, owner_n;
  logic        rw_q, rw_n;
  logic [31:0] addr_q, addr_n;
  logic [3:0]  beat_q, beat_n;
  logic [3:0]  last_q, last_n;
  logic        rvalid_q;
  logic        pick_en;
  logic [31:0] sel_addr;
  logic [1:0]  sel_size;
  logic        unused_range;

  assign pick_en = (state == IDLE) && !reset;

  mem_arb_pick u_pick (
    .clock  (clock),
    .reset  (reset),
    .en     (pick_en),
    .if_req (if_req),
    .dm_req (dm_req),
    .if_gnt (if_gnt),
    .dm_gnt (dm_gnt)
  );

  assign sel_addr = dm_gnt ? dm_addr : if_addr;
  assign sel_size = dm_gnt ? dm_size : if_size;

  // out-of-range flag kept for a future error output
  assign unused_range = (addr_q < BASE_ADDR) ||
                        ((addr_q - BASE_ADDR) >= MEM_DEPTH);

  assign mem_access_size  = 2'b00;
  assign mem_do_wm_bypass = 1'b0;

  assign if_rvalid = rvalid_q && (owner_q == OWNER_IF);
  assign dm_rvalid = rvalid_q && (owner_q == OWNER_DM);
  assign if_rdata  = mem_data_out;
  assign dm_rdata  = mem_data_out;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      owner_q  <= OWNER_IF;
      rw_q     <= 1'b1;
      addr_q   <= '0;
      beat_q   <= '0;
      last_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state    <= state_n;
      owner_q  <= owner_n;
      rw_q     <= rw_n;
      addr_q   <= addr_n;
      beat_q   <= beat_n;
      last_q   <= last_n;
      rvalid_q <= (state == BURST) && rw_q;
    end
  end

  always_comb begin
    state_n     = state;
    owner_n     = owner_q;
    rw_n        = rw_q;
    addr_n      = addr_q;
    beat_n      = beat_q;
    last_n      = last_q;
    mem_enable  = 1'b0;
    mem_rw      = 1'b1;
    mem_address = '0;
    mem_data_in = '0;
    dm_wack     = 1'b0;
    dm_done     = 1'b0;
    if_done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (if_gnt || dm_gnt) begin
          owner_n = dm_gnt ? OWNER_DM : OWNER_IF;
          rw_n    = dm_gnt ? dm_rw : 1'b1;
          addr_n  = {sel_addr[31:2], 2'b00};
          beat_n  = '0;
          last_n  = 4'(size_to_beats(sel_size) - 5'd1);
          state_n = BURST;
        end
      end
      BURST: begin
        mem_enable  = 1'b1;
        mem_rw      = rw_q;
        mem_address = addr_q;
        addr_n      = addr_q + 32'd4;
        beat_n      = beat_q + 4'd1;
        // only the data side ever writes
        if (!rw_q) begin
          mem_data_in = dm_wdata;
          dm_wack     = 1'b1;
        end
        if (beat_q == last_q) begin
          beat_n = '0;
          if (rw_q) begin
            state_n = DRAIN;
          end else begin
            dm_done = 1'b1;
            state_n = IDLE;
          end
        end
      end
      DRAIN: begin
        if_done = (owner_q == OWNER_IF);
        dm_done = (owner_q == OWNER_DM);
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port byte-addressed memory between two requesters: instruction fetch (read-only) and data memory (load/store).
- The memory has no burst mode, so this block sequences multi-word requests as back-to-back single-word accesses (access_size 00) with incrementing address.
- Returns read data and per-beat handshakes to the winning requester.
- Sits between the fetch/memory pipeline stages and the memory instance.

Parameters:
- BASE_ADDR, 32'h80020000, lowest legal byte address; a request below it raises the error flag in optional checking.
- MEM_DEPTH, 1048576, memory size in bytes; used only by optional checking.

Ports:
- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  32  fetch start byte address
- if_size  in  2  burst length: 00=1, 01=4, 10=8, 11=16 words
- if_gnt  out  1  request accepted (1-cycle pulse)
- if_rvalid  out  1  if_rdata valid this cycle
- if_rdata  out  32  fetch read word
- if_done  out  1  final beat of fetch burst
- dm_req  in  1  data request; held until dm_gnt
- dm_rw  in  1  1=read, 0=write (same sense as memory rw)
- dm_addr  in  32  data start byte address
- dm_size  in  2  burst length encoding as if_size
- dm_wdata  in  32  write word for the current beat
- dm_gnt  out  1  request accepted (pulse)
- dm_wack  out  1  dm_wdata consumed this cycle; advance to next word
- dm_rvalid  out  1  dm_rdata valid
- dm_rdata  out  32  data read word
- dm_done  out  1  final beat of data burst
- mem_address  out  32  to memory address
- mem_data_in  out  32  to memory data_in
- mem_access_size  out  2  always 2'b00
- mem_rw  out  1  to memory rw
- mem_enable  out  1  to memory enable
- mem_do_wm_bypass  out  1  always 0
- mem_data_out  in  32  from memory data_out; registered, valid the cycle after the read issue

Behaviour:
- **States:** IDLE, BURST, DRAIN.
- **Reset:** state=IDLE; all gnt/rvalid/wack/done = 0; mem_enable=0; mem_rw=1; mem_address=0; beat counter=0.
- **Reset mid-burst:** abort immediately; no done pulse; a pending rvalid is suppressed.
- **IDLE arbitration:**
  - If any req is high, assert the winner's gnt combinationally in the same cycle.
  - Latch owner, address with [1:0] forced to 00, rw (fetch is always read) and beat count N = 1/4/8/16.
  - Go to BURST.
  - Default policy is fixed priority: data over fetch.
  - A non-granted req stays pending; requesters must hold req/addr/size until gnt and may drop req after it.
- **BURST:** exactly one beat per cycle, no bubbles.
  - Drives mem_enable=1, mem_rw=latched rw, mem_address = start + 4*k (k = 0..N-1, 32-bit wrap, no carry check).
  - Write beat: mem_data_in = dm_wdata (combinational pass), dm_wack=1.
  - Last write beat (k = N-1) also asserts dm_done, then goes to IDLE.
  - After the last read beat, go to DRAIN.
- **Read return:** owner's rvalid is registered: high in cycle t+1 for a beat issued in cycle t. owner rdata = mem_data_out.
  - The DRAIN cycle returns the final word with done=1 and rvalid=1, then goes to IDLE.
  - Non-owner rvalid/done/wack stay 0; non-owner rdata is don't-care.
- **Latency:**
  - write burst = 1 grant cycle + N beat cycles.
  - read burst = 1 grant cycle + N + 1 cycles.
  - Next grant is earliest in the IDLE cycle after done.
- **Simultaneous events:** both req high in IDLE → one grant only. A request arriving during BURST/DRAIN waits.
- mem_busy is not used for flow control; the memory completes a single-word access every cycle.

Optional Feature:
- **Macro:** MEM_ARB_RR_EN.
- **Defined:**
  - Round-robin arbitration. A 1-bit last_owner register (reset = fetch) gives priority to the requester not granted most recently.
  - Ties alternate: a permanent dual request yields grants D, F, D, F….
  - A lone requester is always granted.
- **Undefined:** fixed priority, data always wins; fetch can starve under continuous dm_req.

Decomposition:
- **Shared package** mem_pkg holds:
  - BASE_ADDR;
  - size encodings SZ_1/SZ_4/SZ_8/SZ_16;
  - function size_to_beats;
  - state enum;
  - OWNER_IF/OWNER_DM constants.
- **Sub-module** mem_arb_pick: combinational winner select with optional round-robin state. Keeps the sequencer FSM independent of arbitration policy.

Test Plan:
- **Single fetch:** if_req, if_addr=0x80020000, if_size=00; memory preloaded 0xDEADBEEF → if_gnt in cycle 0, mem_enable cycle 1, if_rvalid+if_done cycle 2 with rdata=0xDEADBEEF.
- **4-beat write:** dm_rw=0, dm_addr=0x80020010, dm_size=01, wdata 1,2,3,4 advanced on each dm_wack → mem_address 0x..10/14/18/1C on consecutive cycles; dm_done with 4th wack; readback equals 1..4.
- **Collision:** if_req and dm_req rise together.
  - Without macro: dm_gnt first, if_gnt in the IDLE cycle after dm_done.
  - With MEM_ARB_RR_EN and continuous requests: grant order D, F, D.
- **Misaligned/wrap:** dm_addr=0x80020013, size=00 → mem_address=0x80020010. Start 0xFFFFFFFC with 4-beat read → addresses wrap to 0x00000000 onward (address only, no data check).
- **Reset mid-burst:** reset asserted in beat 3 of a 16-beat read → next cycle mem_enable=0, no rvalid/done; a fresh single read then completes normally.
- **Back-to-back:** 8-beat read then single write → exactly 8 consecutive mem_enable cycles, DRAIN, IDLE grant, 1 write beat; no idle cycles inside bursts.
